// File: rtl/riscv_run_pkg.sv
// -----------------------------------------------------------------------------
// riscv_run_pkg
// Shared definitions for the RISC-V run controller:
//   - run_state_e : controller FSM state encoding
//   - calc_cw     : width of a counter that must hold values 0..max_val
//   - calc_aw     : width of a register-file address for n registers
// -----------------------------------------------------------------------------
package riscv_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    // Counter width able to represent 0..max_val inclusive (never below 1 bit).
    function automatic int calc_cw(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Address width for a register file of n entries (never below 1 bit).
    function automatic int calc_aw(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/run_counter.sv
// -----------------------------------------------------------------------------
// run_counter
// Up-counter with synchronous clear, count enable and saturation at MaxVal.
// Priority: rst > clr > en.  Once at MaxVal the count holds (no wrap).
// Ports:
//   clk  in  1   clock
//   rst  in  1   synchronous active-high reset (count -> 0)
//   clr  in  1   synchronous clear (count -> 0)
//   en   in  1   increment this cycle (ignored when saturated)
//   cnt  out W   registered count
// -----------------------------------------------------------------------------
module run_counter #(
    parameter int W      = 4,
    parameter int MaxVal = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V  = W'(MaxVal);
    localparam logic [W-1:0] ONE_V  = W'(1);
    localparam logic [W-1:0] ZERO_V = W'(0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next-count selection: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ZERO_V;
        end else if (en && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_run_ctrl
// Run controller placed above a RISC-V core: holds the core in reset, releases
// it for a bounded run, counts retirements, shadows one architectural register
// from the write-back port and reports pass/timeout when the run ends.
//
// Parameters:
//   Bits       write-back data width
//   N          register count (address width AW = calc_aw(N))
//   NumInst    retirements that complete a run
//   RstCycles  core reset pulse length in cycles (>= 1)
//   MaxCycles  run-phase cycle budget (>= 1), CW = calc_cw(MaxCycles)
//   ChkReg     register whose final value is compared (1..N-1)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin/restart a run (accepted in IDLE and DONE only)
//   exp_data            expected final ChkReg value, sampled at completion
//   retire              one instruction retired this cycle
//   wb_en/addr/data     core register write-back
//   core_rst            reset to the core (high except during RUN)
//   busy, done          run in progress / run finished
//   pass, timeout       run result flags (valid while done)
//   cycle_cnt           run cycles elapsed (saturates at MaxCycles)
//   retired_cnt         retirements counted (saturates at NumInst)
// -----------------------------------------------------------------------------
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int  Bits      = 64,
    parameter int  N         = 32,
    parameter int  NumInst   = 6,
    parameter int  RstCycles = 2,
    parameter int  MaxCycles = 20,
    parameter int  ChkReg    = 5,
    localparam int AW        = calc_aw(N),
    localparam int CW        = calc_cw(MaxCycles),
    localparam int RW        = calc_cw(NumInst)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [Bits-1:0] exp_data,
    input  logic            retire,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [Bits-1:0] wb_data,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [CW-1:0]   cycle_cnt,
    output logic [RW-1:0]   retired_cnt
);

    localparam int PW = calc_cw(RstCycles);

    // Compare points are one below the terminal value: the transition edge is
    // the same edge that increments the counter onto its terminal value.
    localparam logic [CW-1:0] CYC_LAST = CW'(MaxCycles - 1);
    localparam logic [RW-1:0] RET_LAST = RW'(NumInst - 1);
    localparam logic [PW-1:0] RST_LAST = PW'(RstCycles - 1);
    localparam logic [AW-1:0] CHK_ADDR = AW'(ChkReg);

    run_state_e      state_q,    state_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            pass_q,     pass_d;
    logic            timeout_q,  timeout_d;
    logic [Bits-1:0] shadow_q,   shadow_d;

    logic            cnt_clr_s;
    logic            cyc_en_s;
    logic            ret_en_s;
    logic            rst_en_s;
    logic            complete_s;
    logic            budget_out_s;

    logic [CW-1:0]   cyc_cnt_q;
    logic [RW-1:0]   ret_cnt_q;
    logic [PW-1:0]   rst_cnt_q;

    // Run-phase cycle counter.
    run_counter #(.W(CW), .MaxVal(MaxCycles)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .en  (cyc_en_s),
        .cnt (cyc_cnt_q)
    );

    // Retirement counter.
    run_counter #(.W(RW), .MaxVal(NumInst)) u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .en  (ret_en_s),
        .cnt (ret_cnt_q)
    );

    // Cycles spent in the core-reset phase.
    run_counter #(.W(PW), .MaxVal(RstCycles)) u_rst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .en  (rst_en_s),
        .cnt (rst_cnt_q)
    );

    // FSM next-state, next-output, counter control and shadow-register update.
    always_comb begin
        state_d      = state_q;
        core_rst_d   = core_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        shadow_d     = shadow_q;
        cnt_clr_s    = 1'b0;
        cyc_en_s     = 1'b0;
        ret_en_s     = 1'b0;
        rst_en_s     = 1'b0;
        complete_s   = 1'b0;
        budget_out_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RESET;
                    core_rst_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    shadow_d   = {Bits{1'b0}};
                    cnt_clr_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end

            ST_RESET: begin
                // retire/wb_* are deliberately not looked at here.
                rst_en_s = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b0;
                end else begin
                    state_d = ST_RESET;
                end
            end

            ST_RUN: begin
                cyc_en_s = 1'b1;
                ret_en_s = retire;

                // x0 can never match because ChkReg is at least 1.
                if (wb_en && (wb_addr == CHK_ADDR)) begin
                    shadow_d = wb_data;
                end else begin
                    shadow_d = shadow_q;
                end

                complete_s   = retire && (ret_cnt_q == RET_LAST);
                budget_out_s = (cyc_cnt_q == CYC_LAST);

                // Completion is checked first so it wins a tie with the budget.
                if (complete_s) begin
                    state_d    = ST_DONE;
                    core_rst_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (shadow_d == exp_data);
                    timeout_d  = 1'b0;
                end else if (budget_out_s) begin
                    state_d    = ST_DONE;
                    core_rst_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                // Unreachable encoding: fall back to the safe idle condition.
                state_d    = ST_IDLE;
                core_rst_d = 1'b1;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                pass_d     = 1'b0;
                timeout_d  = 1'b0;
                shadow_d   = {Bits{1'b0}};
                cnt_clr_s  = 1'b1;
            end
        endcase
    end

    // FSM state, registered outputs and shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            shadow_q   <= {Bits{1'b0}};
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            shadow_q   <= shadow_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_cnt   = cyc_cnt_q;
    assign retired_cnt = ret_cnt_q;

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameter Bits, default 64: write-back data width.
REQ-002 SHALL have parameter N, default 32: register count; write-back address width AW = $clog2(N).
REQ-003 SHALL have parameter NumInst, default 6: retirements that end a run successfully.
REQ-004 SHALL have parameter RstCycles, default 2 (legal >= 1): core reset pulse length in cycles.
REQ-005 SHALL have parameter MaxCycles, default 20 (legal >= 1): run-phase cycle budget; CW = $clog2(MaxCycles+1).
REQ-006 SHALL have parameter ChkReg, default 5 (legal 1..N-1): register whose final value is checked.
REQ-007 SHALL have ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-008 SHALL have ports: start in 1, begin or restart a run; exp_data in Bits, expected final ChkReg value, sampled at completion.
REQ-009 SHALL have ports: retire in 1, one instruction retired this cycle; wb_en in 1, wb_addr in AW, wb_data in Bits, register write-back.
REQ-010 SHALL have ports: core_rst out 1, reset to the core; busy out 1; done out 1; pass out 1; timeout out 1.
REQ-011 SHALL have ports: cycle_cnt out CW, run cycles elapsed; retired_cnt out $clog2(NumInst+1), retirements counted.

Function
REQ-012 SHALL implement an FSM with states IDLE, RESET, RUN, DONE; all outputs registered.
REQ-013 IDLE: core_rst=1, busy=0. start=1 -> RESET, clear both counters, pass, timeout, shadow register.
REQ-014 RESET: core_rst=1, busy=1. After exactly RstCycles cycles in RESET -> RUN. retire and wb_* are ignored.
REQ-015 RUN: core_rst=0, busy=1. cycle_cnt increments each cycle. retired_cnt increments on each cycle with retire=1.
REQ-016 RUN: wb_en=1 with wb_addr==ChkReg loads wb_data into an internal shadow register. Writes to other addresses, including x0, leave it unchanged.
REQ-017 RUN -> DONE with pass = (shadow == exp_data, after including the same-cycle write), timeout=0, on the cycle retire brings retired_cnt to NumInst.
REQ-018 RUN -> DONE with timeout=1, pass=0, when cycle_cnt reaches MaxCycles without completion.
REQ-019 If completion and budget exhaustion occur on the same cycle, completion SHALL win (timeout=0).
REQ-020 DONE: done=1, busy=0, core_rst=1. Counters, pass, and timeout hold until the next start.
REQ-021 start=1 in DONE SHALL restart exactly as in IDLE. start in RESET or RUN SHALL be ignored.
REQ-022 retired_cnt never exceeds NumInst. cycle_cnt never exceeds MaxCycles (no wrap).
REQ-023 Latency: core_rst deasserts RstCycles+1 cycles after the start cycle.

Reset
REQ-024 rst=1 SHALL, on the next clk edge, force IDLE with core_rst=1, busy=0, done=0, pass=0, timeout=0, both counts 0, shadow 0, in any state including mid-RUN.
REQ-025 rst SHALL take priority over start on the same cycle.

Structure
REQ-026 Shared package riscv_run_pkg SHALL hold the state enum type and the width helper functions (CW, AW).
REQ-027 One sub-module, run_counter, SHALL provide the parametrised counter with clear, enable, and saturation. It is instantiated for cycle_cnt, retired_cnt, and the RESET-phase count.
REQ-028 SHALL be synthesizable and instantiable above Procesador_RISC_V, driving its rst from core_rst.

Verification
REQ-029 Defaults: start pulse, 6 retire pulses at run cycles 3..8, final write ChkReg=5 with 0x2A, exp_data=0x2A -> done=1, pass=1, timeout=0, retired_cnt=6, cycle_cnt=8.
REQ-030 Same run but exp_data=0x2B -> done=1, pass=0, timeout=0.
REQ-031 Only 3 retires -> done=1, timeout=1, pass=0, cycle_cnt=20, retired_cnt=3.
REQ-032 Sixth retire on run cycle 20 -> pass per compare, timeout=0; write to x5 on that same cycle is included in the compare.
REQ-033 rst asserted in RUN at cycle 4 -> next cycle IDLE, all outputs at reset values; a following start -> core_rst high exactly 2 cycles.
REQ-034 start asserted in RUN -> no effect; start in DONE -> counters clear and the run repeats identically.
